// File: rtl/alarm_tick_sequencer_if.sv
// Avalon-MM write-only link between the alarm tick sequencer (master) and the
// 16-bit interval-timer slave, plus the timer's level interrupt.
interface alarm_tick_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic        irq;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  irq
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output irq
  );
endinterface

// File: rtl/alarm_tick_sequencer.sv
// Programs the interval timer for a 1 Hz period, services its irq and keeps a 24-hour hh:mm:ss count.
// Optional alarm comparator enabled by defining TOD_ALARM_EN.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  CFG_PL   | launch period-low write (addr 2)
//  CFG_PH   | launch period-high write (addr 3)
//  CFG_CTRL | launch control write (addr 1, CTRL_WORD)
//  RUN      | timer configured, waiting for irq
//  ACK      | status write (addr 0) on the bus, tick high
//  GAP      | idle cycle so the registered irq can fall
module alarm_tick_sequencer #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter logic [15:0] CTRL_WORD = 16'h0007
) (
  input  logic                          clk,
  input  logic                          reset,
  alarm_tick_sequencer_if.master        tmr,
  input  logic                          set_valid,
  input  logic [4:0]                    set_hh,
  input  logic [5:0]                    set_mm,
  input  logic [5:0]                    set_ss,
  output logic [4:0]                    hh,
  output logic [5:0]                    mm,
  output logic [5:0]                    ss,
  output logic                          tick,
  output logic                          running
`ifdef TOD_ALARM_EN
  ,
  input  logic [4:0]                    alarm_hh,
  input  logic [5:0]                    alarm_mm,
  input  logic                          alarm_arm,
  input  logic                          alarm_clear,
  output logic                          alarm_active
`endif
);

  localparam logic [31:0] PERIOD = CLK_HZ - 32'd1;

  typedef enum logic [2:0] {
    CFG_PL,
    CFG_PH,
    CFG_CTRL,
    RUN,
    ACK,
    GAP
  } state_t;

  state_t      state;
  logic [2:0]  bus_address;
  logic        bus_chipselect;
  logic        bus_write_n;
  logic [15:0] bus_writedata;

  assign tmr.address    = bus_address;
  assign tmr.chipselect = bus_chipselect;
  assign tmr.write_n    = bus_write_n;
  assign tmr.writedata  = bus_writedata;

  // Bus strobes are registered: each state launches the write that is on the bus next cycle,
  // so the status write and tick land in the same cycle the FSM sits in ACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= CFG_PL;
      bus_address    <= 3'd0;
      bus_chipselect <= 1'b0;
      bus_write_n    <= 1'b1;
      bus_writedata  <= 16'h0000;
      tick           <= 1'b0;
      running        <= 1'b0;
    end else begin
      bus_address    <= 3'd0;
      bus_chipselect <= 1'b0;
      bus_write_n    <= 1'b1;
      bus_writedata  <= 16'h0000;
      tick           <= 1'b0;
      unique case (state)
        CFG_PL: begin
          bus_address    <= 3'd2;
          bus_chipselect <= 1'b1;
          bus_write_n    <= 1'b0;
          bus_writedata  <= PERIOD[15:0];
          state          <= CFG_PH;
        end
        CFG_PH: begin
          bus_address    <= 3'd3;
          bus_chipselect <= 1'b1;
          bus_write_n    <= 1'b0;
          bus_writedata  <= PERIOD[31:16];
          state          <= CFG_CTRL;
        end
        CFG_CTRL: begin
          bus_address    <= 3'd1;
          bus_chipselect <= 1'b1;
          bus_write_n    <= 1'b0;
          bus_writedata  <= CTRL_WORD;
          state          <= RUN;
        end
        RUN: begin
          running <= 1'b1;
          if (tmr.irq) begin
            bus_address    <= 3'd0;
            bus_chipselect <= 1'b1;
            bus_write_n    <= 1'b0;
            bus_writedata  <= 16'h0000;
            tick           <= 1'b1;
            state          <= ACK;
          end
        end
        ACK: begin
          state <= GAP;
        end
        GAP: begin
          state <= RUN;
        end
        default: begin
          state <= CFG_PL;
        end
      endcase
    end
  end

  logic [4:0] set_hh_c;
  logic [5:0] set_mm_c;
  logic [5:0] set_ss_c;
  logic [4:0] hh_nxt;
  logic [5:0] mm_nxt;
  logic [5:0] ss_nxt;
  logic       ss_wrap;
  logic       mm_wrap;

  always_comb begin
    set_hh_c = (set_hh > 5'd23) ? 5'd23 : set_hh;
    set_mm_c = (set_mm > 6'd59) ? 6'd59 : set_mm;
    set_ss_c = (set_ss > 6'd59) ? 6'd59 : set_ss;

    ss_wrap = (ss == 6'd59);
    mm_wrap = (mm == 6'd59);
    ss_nxt  = ss_wrap ? 6'd0 : ss + 6'd1;
    mm_nxt  = mm;
    hh_nxt  = hh;
    if (ss_wrap) begin
      mm_nxt = mm_wrap ? 6'd0 : mm + 6'd1;
      if (mm_wrap) begin
        hh_nxt = (hh == 5'd23) ? 5'd0 : hh + 5'd1;
      end
    end
  end

  // A load in the tick cycle overrides that tick's increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      hh <= 5'd0;
      mm <= 6'd0;
      ss <= 6'd0;
    end else if (set_valid) begin
      hh <= set_hh_c;
      mm <= set_mm_c;
      ss <= set_ss_c;
    end else if (tick) begin
      hh <= hh_nxt;
      mm <= mm_nxt;
      ss <= ss_nxt;
    end
  end

`ifdef TOD_ALARM_EN
  logic alarm_hit;

  assign alarm_hit = tick && !set_valid && alarm_arm &&
                     (hh_nxt == alarm_hh) && (mm_nxt == alarm_mm) && (ss_nxt == 6'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_active <= 1'b0;
    end else if (alarm_clear) begin
      alarm_active <= 1'b0;
    end else if (alarm_hit) begin
      alarm_active <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alarm_tick_sequencer.sv
// Scoreboard bench for alarm_tick_sequencer: a timer model raises irq on request, the driver
// pushes expected bus writes and seconds-of-day results, and a negedge monitor pops and compares.
module tb_alarm_tick_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       set_valid = 1'b0;
  logic [4:0] set_hh = '0;
  logic [5:0] set_mm = '0;
  logic [5:0] set_ss = '0;
  logic [4:0] hh;
  logic [5:0] mm;
  logic [5:0] ss;
  logic       tick;
  logic       running;
  logic       tmr_irq = 1'b0;
`ifdef TOD_ALARM_EN
  logic [4:0] alarm_hh = '0;
  logic [5:0] alarm_mm = '0;
  logic       alarm_arm = 1'b0;
  logic       alarm_clear = 1'b0;
  logic       alarm_active;
`endif

  alarm_tick_sequencer_if bus ();
  assign bus.irq = tmr_irq;

  alarm_tick_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .tmr       (bus),
    .set_valid (set_valid),
    .set_hh    (set_hh),
    .set_mm    (set_mm),
    .set_ss    (set_ss),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .tick      (tick),
    .running   (running)
`ifdef TOD_ALARM_EN
    ,
    .alarm_hh     (alarm_hh),
    .alarm_mm     (alarm_mm),
    .alarm_arm    (alarm_arm),
    .alarm_clear  (alarm_clear),
    .alarm_active (alarm_active)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: time of day as plain seconds since midnight.
  localparam int unsigned PERIOD_VAL = 50_000_000 - 1;
  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_wr[$];
  logic [16:0] exp_tod[$];
  int          tod = 0;

  function automatic logic [16:0] hms(input int t);
    return {5'(t / 3600), 6'((t / 60) % 60), 6'(t % 60)};
  endfunction

  function automatic int clamp_tod(input int h, input int m, input int s);
    int hc, mc, sc;
    hc = (h > 23) ? 23 : h;
    mc = (m > 59) ? 59 : m;
    sc = (s > 59) ? 59 : s;
    return hc * 3600 + mc * 60 + sc;
  endfunction

  // Timer model: irq raised on request, dropped by the status write.
  int irq_req  = 0;
  int irq_done = 0;
  always @(posedge clk) begin
    if (bus.chipselect && !bus.write_n && bus.address == 3'd0) tmr_irq <= 1'b0;
    else if (irq_req != irq_done) begin
      tmr_irq  <= 1'b1;
      irq_done <= irq_req;
    end
  end

  // Monitor: every bus write and every post-tick time value is popped and compared.
  bit          chk_time = 0;
  wr_t         mon_w;
  logic [16:0] mon_t;
  always @(negedge clk) begin
    if (chk_time) begin
      chk_time = 0;
      if (exp_tod.size() == 0) check("tod_unexpected", {15'd0, hh, mm, ss}, 32'h1FFFF);
      else begin
        mon_t = exp_tod.pop_front();
        check("tod_after_tick", {15'd0, hh, mm, ss}, {15'd0, mon_t});
      end
    end
    if (bus.chipselect === 1'b1 && bus.write_n === 1'b0) begin
      if (exp_wr.size() == 0) check("write_unexpected", {13'd0, bus.address, bus.writedata}, 32'hFFFF_FFFF);
      else begin
        mon_w = exp_wr.pop_front();
        check("bus_write", {13'd0, bus.address, bus.writedata}, {13'd0, mon_w});
      end
    end
    if (tick === 1'b1) chk_time = 1;
  end

  task automatic wait_tick(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_timeout: got no tick required tick within 20 cycles");
    end
  endtask

  task automatic apply_reset(input bit with_irq);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_chipselect", {31'd0, bus.chipselect}, 32'd0);
    check("rst_write_n", {31'd0, bus.write_n}, 32'd1);
    check("rst_address", {29'd0, bus.address}, 32'd0);
    check("rst_writedata", {16'd0, bus.writedata}, 32'd0);
    check("rst_time", {15'd0, hh, mm, ss}, 32'd0);
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_running", {31'd0, running}, 32'd0);
    tod = 0;
    exp_wr.push_back('{3'd2, PERIOD_VAL[15:0]});
    exp_wr.push_back('{3'd3, PERIOD_VAL[31:16]});
    exp_wr.push_back('{3'd1, 16'h0007});
    if (with_irq) begin
      tod = 1;
      exp_wr.push_back('{3'd0, 16'h0000});
      exp_tod.push_back(hms(tod));
      irq_req++;
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("running_during_cfg", {31'd0, running}, 32'd0);
    @(negedge clk);
    check("running_after_cfg", {31'd0, running}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic op_irq(input bit chk_lat);
    int lat;
    tod = (tod + 1) % 86400;
    exp_wr.push_back('{3'd0, 16'h0000});
    exp_tod.push_back(hms(tod));
    irq_req++;
    wait_tick(lat);
    if (chk_lat) check("irq_to_tick_cycles", lat, 32'd2);
    repeat (3) @(negedge clk);
  endtask

  task automatic op_set(input int h, input int m, input int s);
    tod = clamp_tod(h, m, s);
    set_hh = 5'(h);
    set_mm = 6'(m);
    set_ss = 6'(s);
    set_valid = 1'b1;
    @(negedge clk);
    set_valid = 1'b0;
  endtask

  task automatic op_set_in_ack(input int h, input int m, input int s);
    int lat;
    tod = clamp_tod(h, m, s);
    exp_wr.push_back('{3'd0, 16'h0000});
    exp_tod.push_back(hms(tod));
    irq_req++;
    wait_tick(lat);
    set_hh = 5'(h);
    set_mm = 6'(m);
    set_ss = 6'(s);
    set_valid = 1'b1;
    @(negedge clk);
    set_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic op_reset_in_ack();
    int lat;
    exp_wr.push_back('{3'd0, 16'h0000});
    exp_tod.push_back(hms(0));
    irq_req++;
    wait_tick(lat);
    apply_reset(1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    apply_reset(1'b0);
    op_irq(1'b1);
    op_set(23, 59, 59);
    op_irq(1'b1);
    op_set(12, 0, 0);
    op_set_in_ack(12, 34, 56);
    op_irq(1'b1);
    op_set(31, 63, 63);
    op_irq(1'b1);
    op_reset_in_ack();
    op_irq(1'b1);
    apply_reset(1'b1);
    op_irq(1'b1);

    for (int k = 0; k < 60; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) op_irq(1'b1);
      else if (r <= 7)
        op_set($urandom_range(0, 31), $urandom_range(0, 1) ? 59 : $urandom_range(0, 63),
               $urandom_range(55, 63));
      else
        op_set_in_ack($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
    end
    op_irq(1'b1);

`ifdef TOD_ALARM_EN
    alarm_hh  = 5'd7;
    alarm_mm  = 6'd30;
    alarm_arm = 1'b1;
    op_set(7, 30, 0);
    @(negedge clk);
    check("alarm_not_set_by_load", {31'd0, alarm_active}, 32'd0);
    op_set(7, 29, 59);
    op_irq(1'b1);
    check("alarm_on_match", {31'd0, alarm_active}, 32'd1);
    alarm_clear = 1'b1;
    @(negedge clk);
    alarm_clear = 1'b0;
    check("alarm_cleared", {31'd0, alarm_active}, 32'd0);
    alarm_arm = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check("pending_writes_left", exp_wr.size(), 32'd0);
    check("pending_times_left", exp_tod.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
